// File: rtl/t03_sprite_renderer.sv
// t03_sprite_renderer: scaled, mirrorable, blinking sprite overlay with one-cycle registered pixel output.
// Ports: clk/rst (sync, active-high); Hcnt/Vcnt current beam position; x/y sprite offset and
// mode {blink, mirror_x} latched at frame start; sprite packed bitmap (pixel 0 in MSBs);
// color/is_displayed/opaque registered pixel result for the position sampled one edge earlier.
module t03_sprite_renderer #(
    parameter int SPR_W = 15,
    parameter int SPR_H = 20,
    parameter int SCALE_X = 1,
    parameter int SCALE_Y = 5,
    parameter int ORIGIN_X = 37,
    parameter int ORIGIN_Y = 29,
    parameter logic [7:0] KEY_COLOR = 8'hE0,
    parameter logic [7:0] SUB_COLOR = 8'h07,
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic [10:0] Hcnt,
    input  logic [10:0] Vcnt,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [1:0] mode,
    input  logic [SPR_W*SPR_H*8-1:0] sprite,
    output logic [7:0] color,
    output logic is_displayed,
    output logic opaque
);
    localparam int NPIX = SPR_W * SPR_H;
    localparam int IW = $clog2(NPIX * 8);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [11:0] WIN_W = 12'(SPR_W * SCALE_X);
    localparam logic [11:0] WIN_H = 12'(SPR_H * SCALE_Y);
    localparam logic [10:0] SX = 11'(SCALE_X);
    localparam logic [10:0] SY = 11'(SCALE_Y);
    localparam logic [10:0] LAST_C = 11'(SPR_W - 1);
    localparam logic [10:0] OX = 11'(ORIGIN_X);
    localparam logic [10:0] OY = 11'(ORIGIN_Y);
    localparam logic [31:0] LAST_PIX = 32'(NPIX - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [10:0] px, py, dx, dy, c_raw, col, row;
    logic [1:0] mode_q;
    logic [FW-1:0] fcnt;
    logic blink_phase, frame_start, in_win, visible;
    logic [31:0] idx, base;
    logic [IW-1:0] bit_lo;
    logic [7:0] p, p_map;

    always_comb begin
        frame_start = Hcnt == 11'd0 && Vcnt == 11'd0;
        // upper bounds widened to 12 bits so a window near column/line 2047 clips instead of wrapping
        in_win = Hcnt >= px && {1'b0, Hcnt} < {1'b0, px} + WIN_W &&
                 Vcnt >= py && {1'b0, Vcnt} < {1'b0, py} + WIN_H;
        dx = Hcnt - px;
        dy = Vcnt - py;
        c_raw = dx / SX;
        row = dy / SY;
        col = mode_q[0] ? LAST_C - c_raw : c_raw;
        // out-of-window positions park on pixel 0 so the select always stays inside the bus
        idx = in_win ? 32'(row) * 32'(SPR_W) + 32'(col) : 32'd0;
        base = LAST_PIX - idx;
        bit_lo = IW'(base << 3);
        p = sprite[bit_lo +: 8];
        p_map = p == KEY_COLOR ? SUB_COLOR : p;
        visible = in_win && !(mode_q[1] && blink_phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color <= 8'h00;
            is_displayed <= 1'b0;
            opaque <= 1'b0;
            px <= OX;
            py <= OY;
            mode_q <= 2'b00;
            fcnt <= '0;
            blink_phase <= 1'b0;
        end else begin
            color <= visible ? p_map : 8'h00;
            is_displayed <= visible;
            opaque <= visible && p != 8'h00;
            if (frame_start) begin
                px <= x + OX;
                py <= y + OY;
                mode_q <= mode;
                fcnt <= fcnt == F_LAST ? '0 : fcnt + 1'b1;
                if (fcnt == F_LAST) blink_phase <= ~blink_phase;
            end
        end
    end
endmodule

// File: tb/tb_t03_sprite_renderer.sv
// tb_t03_sprite_renderer: directed and randomized checks of the sprite renderer against a frame-level model.
module tb_t03_sprite_renderer;
    localparam int W = 15, H = 20, SX = 1, SY = 5, OX = 37, OY = 29, BF = 2, N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [10:0] Hcnt = '0, Vcnt = '0, x = '0, y = '0;
    logic [1:0] mode = '0;
    logic [N*8-1:0] sprite = '0;
    logic [7:0] color;
    logic is_displayed, opaque;

    logic [7:0] pix [N];
    int m_px = OX, m_py = OY, m_nfr = 0;
    logic [1:0] m_mode = 2'b00;
    logic [7:0] exp_c;
    logic exp_d, exp_o;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    t03_sprite_renderer #(.SPR_W(W), .SPR_H(H), .SCALE_X(SX), .SCALE_Y(SY), .ORIGIN_X(OX),
        .ORIGIN_Y(OY), .KEY_COLOR(8'hE0), .SUB_COLOR(8'h07), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .Hcnt(Hcnt), .Vcnt(Vcnt), .x(x), .y(y), .mode(mode),
        .sprite(sprite), .color(color), .is_displayed(is_displayed), .opaque(opaque));

    task automatic set_sprite();
        for (int k = 0; k < N; k++) sprite[8*(N-1-k) +: 8] = pix[k];
    endtask

    task automatic rand_pix();
        for (int k = 0; k < N; k++) begin
            int s;
            s = int'($urandom_range(0, 7));
            pix[k] = s == 0 ? 8'hE0 : s == 1 ? 8'h00 : 8'($urandom);
        end
        set_sprite();
    endtask

    task automatic predict(input int h, input int v);
        logic inw, vis;
        int c, r;
        logic [7:0] pv;
        inw = h >= m_px && h < m_px + W * SX && v >= m_py && v < m_py + H * SY;
        vis = inw && !(m_mode[1] && (m_nfr / BF) % 2 == 1);
        pv = 8'h00;
        if (inw) begin
            c = (h - m_px) / SX;
            if (m_mode[0]) c = W - 1 - c;
            r = (v - m_py) / SY;
            pv = pix[r * W + c];
        end
        exp_d = vis;
        exp_o = vis && pv != 8'h00;
        exp_c = !vis ? 8'h00 : (pv == 8'hE0 ? 8'h07 : pv);
    endtask

    task automatic cyc(input int h, input int v);
        Hcnt = 11'(h);
        Vcnt = 11'(v);
        predict(h, v);
        @(posedge clk);
        if (rst) begin
            m_px = OX; m_py = OY; m_mode = 2'b00; m_nfr = 0;
            exp_c = 8'h00; exp_d = 1'b0; exp_o = 1'b0;
        end else if (h == 0 && v == 0) begin
            m_px = (int'(x) + OX) % 2048;
            m_py = (int'(y) + OY) % 2048;
            m_mode = mode;
            m_nfr++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(5, 5);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rand_pix();
        pix[0] = 8'h1C;
        set_sprite();
        x = 11'd0; y = 11'd0; mode = 2'b00;
        rst = 1'b1;
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== 10'h000) begin bad++; $display("FAIL reset_out: got %h/%b/%b want 00/0/0", color, is_displayed, opaque); end
        rst = 1'b0;
        x = 11'd100;
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h1C, 2'b11}) begin bad++; $display("FAIL reset_px: got %h/%b/%b want 1c/1/1", color, is_displayed, opaque); end
        cyc(0, 0);
        cyc(37, 29);
        total++;
        if (is_displayed !== 1'b0) begin bad++; $display("FAIL moved_px: got d=%b want 0", is_displayed); end
        rst = 1'b1;
        cyc(137, 29);
        total++;
        if ({color, is_displayed, opaque} !== 10'h000) begin bad++; $display("FAIL midframe_rst: got %h/%b/%b want 00/0/0", color, is_displayed, opaque); end
        rst = 1'b0;
        cyc(137, 29);
        total++;
        if (is_displayed !== 1'b0) begin bad++; $display("FAIL post_rst_old: got d=%b want 0", is_displayed); end
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h1C, 2'b11}) begin bad++; $display("FAIL post_rst_new: got %h/%b/%b want 1c/1/1", color, is_displayed, opaque); end
    endtask

    task automatic test_directed();
        do_reset();
        x = 11'd0; y = 11'd0; mode = 2'b00;
        rand_pix();
        pix[0] = 8'h1C; pix[15] = 8'h33; pix[299] = 8'h5A; pix[14] = 8'hA5;
        set_sprite();
        cyc(0, 0);
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h1C, 2'b11}) begin bad++; $display("FAIL dir_basic: got %h/%b/%b want 1c/1/1", color, is_displayed, opaque); end
        pix[0] = 8'hE0; set_sprite();
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h07, 2'b11}) begin bad++; $display("FAIL dir_key: got %h/%b/%b want 07/1/1", color, is_displayed, opaque); end
        pix[0] = 8'h00; set_sprite();
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h00, 2'b10}) begin bad++; $display("FAIL dir_zero: got %h/%b/%b want 00/1/0", color, is_displayed, opaque); end
        cyc(37, 33);
        total++;
        if ({color, is_displayed, opaque} !== {8'h00, 2'b10}) begin bad++; $display("FAIL dir_scale_row0: got %h/%b/%b want 00/1/0", color, is_displayed, opaque); end
        cyc(37, 34);
        total++;
        if ({color, is_displayed, opaque} !== {8'h33, 2'b11}) begin bad++; $display("FAIL dir_scale_row1: got %h/%b/%b want 33/1/1", color, is_displayed, opaque); end
        cyc(36, 29);
        total++;
        if ({color, is_displayed, opaque} !== 10'h000) begin bad++; $display("FAIL dir_left: got %h/%b/%b want 00/0/0", color, is_displayed, opaque); end
        cyc(52, 29);
        total++;
        if ({color, is_displayed, opaque} !== 10'h000) begin bad++; $display("FAIL dir_right: got %h/%b/%b want 00/0/0", color, is_displayed, opaque); end
        cyc(51, 128);
        total++;
        if ({color, is_displayed, opaque} !== {8'h5A, 2'b11}) begin bad++; $display("FAIL dir_last: got %h/%b/%b want 5a/1/1", color, is_displayed, opaque); end
        cyc(51, 129);
        total++;
        if ({color, is_displayed, opaque} !== 10'h000) begin bad++; $display("FAIL dir_below: got %h/%b/%b want 00/0/0", color, is_displayed, opaque); end
        mode = 2'b01;
        cyc(0, 0);
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'hA5, 2'b11}) begin bad++; $display("FAIL dir_mirror: got %h/%b/%b want a5/1/1", color, is_displayed, opaque); end
        cyc(51, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h00, 2'b10}) begin bad++; $display("FAIL dir_mirror_end: got %h/%b/%b want 00/1/0", color, is_displayed, opaque); end
    endtask

    task automatic test_blink();
        do_reset();
        x = 11'd0; y = 11'd0; mode = 2'b10;
        pix[0] = 8'h1C; set_sprite();
        for (int n = 0; n < 6; n++) begin
            logic want;
            want = n == 0 || n == 1 || n == 4 || n == 5;
            if (n > 0) cyc(0, 0);
            cyc(37, 29);
            total++;
            if ({color, is_displayed} !== {want ? 8'h1C : 8'h00, want}) begin bad++; $display("FAIL blink_f%0d: got %h/%b want d=%b", n, color, is_displayed, want); end
            cyc(45, 90);
            total++;
            if (is_displayed !== want) begin bad++; $display("FAIL blink_mid_f%0d: got d=%b want %b", n, is_displayed, want); end
        end
    endtask

    task automatic test_midframe();
        int hs [8] = '{36, 37, 46, 47, 51, 52, 61, 62};
        do_reset();
        x = 11'd0; y = 11'd0; mode = 2'b00;
        cyc(0, 0);
        x = 11'd10; mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            cyc(hs[i], 40);
            total++;
            if (is_displayed !== (hs[i] >= 37 && hs[i] <= 51)) begin bad++; $display("FAIL mid_old h=%0d: got d=%b", hs[i], is_displayed); end
        end
        mode = 2'b00;
        cyc(0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(hs[i], 40);
            total++;
            if (is_displayed !== (hs[i] >= 47 && hs[i] <= 61)) begin bad++; $display("FAIL mid_new h=%0d: got d=%b", hs[i], is_displayed); end
        end
    endtask

    task automatic test_fs_in_window();
        do_reset();
        pix[0] = 8'h1C; pix[14] = 8'h42; set_sprite();
        x = 11'd2011; y = 11'd2019; mode = 2'b01;
        cyc(0, 0);
        x = 11'd0; y = 11'd0; mode = 2'b00;
        cyc(0, 0);
        total++;
        if ({color, is_displayed, opaque} !== {8'h42, 2'b11}) begin bad++; $display("FAIL fs_pre: got %h/%b/%b want 42/1/1", color, is_displayed, opaque); end
        cyc(1, 0);
        total++;
        if (is_displayed !== 1'b0) begin bad++; $display("FAIL fs_post: got d=%b want 0", is_displayed); end
        cyc(37, 29);
        total++;
        if ({color, is_displayed, opaque} !== {8'h1C, 2'b11}) begin bad++; $display("FAIL fs_new: got %h/%b/%b want 1c/1/1", color, is_displayed, opaque); end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 40; f++) begin
            x = 11'($urandom_range(0, 3) == 0 ? $urandom_range(1990, 2047) : $urandom_range(0, 2047));
            y = 11'($urandom_range(0, 3) == 0 ? $urandom_range(1900, 2047) : $urandom_range(0, 2047));
            mode = 2'($urandom);
            rand_pix();
            cyc(0, 0);
            for (int i = 0; i < 40; i++) begin
                int h, v;
                h = (m_px + int'($urandom_range(0, W * SX + 5)) - 3 + 2048) % 2048;
                v = (m_py + int'($urandom_range(0, H * SY + 5)) - 3 + 2048) % 2048;
                if ($urandom_range(0, 7) == 0) h = int'($urandom_range(0, 2047));
                cyc(h, v);
                total++;
                if ({color, is_displayed, opaque} !== {exp_c, exp_d, exp_o}) begin
                    bad++;
                    $display("FAIL rand f%0d (%0d,%0d): got %h/%b/%b want %h/%b/%b", f, h, v, color, is_displayed, opaque, exp_c, exp_d, exp_o);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) pix[k] = 8'h00;
        test_reset();
        test_directed();
        test_blink();
        test_midframe();
        test_fs_in_window();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/t03_sprite_renderer.md
T03_SPRITE_RENDERER -- requirements
Module: t03_sprite_renderer

Interface
REQ-001 SHALL have parameter SPR_W, default 15, sprite width in source pixels.
REQ-002 SHALL have parameter SPR_H, default 20, sprite height in source pixels.
REQ-003 SHALL have parameter SCALE_X, default 1, horizontal pixel replication (>=1).
REQ-004 SHALL have parameter SCALE_Y, default 5, vertical line replication (>=1).
REQ-005 SHALL have parameters ORIGIN_X, default 37, and ORIGIN_Y, default 29, screen offsets added to x/y.
REQ-006 SHALL have parameters KEY_COLOR, default 8'hE0, and SUB_COLOR, default 8'h07, colour substitution pair.
REQ-007 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period (>=1).
REQ-008 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port Hcnt, input, 11, current pixel column.
REQ-011 SHALL have port Vcnt, input, 11, current line.
REQ-012 SHALL have port x, input, 11, requested sprite x offset.
REQ-013 SHALL have port y, input, 11, requested sprite y offset.
REQ-014 SHALL have port mode, input, 2: 00 normal, 01 mirror-X, 10 blink, 11 mirror-X plus blink.
REQ-015 SHALL have port sprite, input, SPR_W*SPR_H*8, bitmap; pixel 0 (top-left) in the 8 MSBs, row-major.
REQ-016 SHALL have port color, output, 8, registered pixel colour.
REQ-017 SHALL have port is_displayed, output, 1, registered in-window-and-visible flag.
REQ-018 SHALL have port opaque, output, 1, registered flag: is_displayed and source pixel nonzero.

Function
REQ-019 Frame start SHALL be the cycle with Hcnt==0 and Vcnt==0.
REQ-020 On frame start, px<=x+ORIGIN_X, py<=y+ORIGIN_Y (11-bit, truncating) and mode_q<=mode; these SHALL be held for the whole frame.
REQ-021 The window SHALL be px<=Hcnt<px+SPR_W*SCALE_X and py<=Vcnt<py+SPR_H*SCALE_Y, upper bounds computed in 12 bits with no wrap (clipped at column/line 2047).
REQ-022 In-window, c=(Hcnt-px)/SCALE_X and r=(Vcnt-py)/SCALE_Y; if mode_q[0]=1 then c=SPR_W-1-c.
REQ-023 Selected pixel p SHALL be sprite bits [8*(SPR_W*SPR_H-1-(r*SPR_W+c))+7 -: 8].
REQ-024 Colour mapping: p==KEY_COLOR -> SUB_COLOR; else p.
REQ-025 A frame counter SHALL increment on each frame start; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
REQ-026 Visible SHALL equal in-window AND NOT (mode_q[1] AND blink_phase).
REQ-027 Latency SHALL be exactly 1 cycle: color/is_displayed/opaque at edge N+1 reflect Hcnt/Vcnt sampled at edge N.
REQ-028 When not visible, color SHALL be 8'h00, is_displayed 0, opaque 0.
REQ-029 Frame start coinciding with an in-window pixel SHALL use pre-update px/py/mode_q for that pixel.
REQ-030 Changes to x, y, mode mid-frame SHALL have no effect until the next frame start.
REQ-031 The sprite bus SHALL be sampled combinationally every cycle (no latching).

Reset
REQ-032 While rst=1 at a clock edge: color=0, is_displayed=0, opaque=0, px=ORIGIN_X, py=ORIGIN_Y, mode_q=00, frame counter=0, blink_phase=0.
REQ-033 Reset asserted mid-frame SHALL take effect on the next edge; first pixel after release uses reset px/py until next frame start.

Verification
REQ-034 Defaults, x=y=0, frame start issued, sprite[2399:2392]=8'h1C; drive Hcnt=37,Vcnt=29 -> next cycle color=8'h1C, is_displayed=1, opaque=1.
REQ-035 Same window, pixel value 8'hE0 -> color=8'h07; pixel 8'h00 -> color=0, is_displayed=1, opaque=0.
REQ-036 Boundaries: Hcnt=36 or 52, Vcnt=29 -> is_displayed=0; Hcnt=51,Vcnt=128 -> is_displayed=1 (pixel 299); Vcnt=129 -> 0.
REQ-037 mode=01, Hcnt=37,Vcnt=29 -> color is pixel 14 (bits [2287:2280]).
REQ-038 mode=10, BLINK_FRAMES=2: frames 0-1 visible, frames 2-3 is_displayed=0 everywhere, frames 4-5 visible.
REQ-039 Change x from 0 to 10 mid-frame -> window stays at Hcnt 37..51 until next frame start, then 47..61.
